// File: rtl/mole_scheduler_if.sv
// mole_scheduler_if
//   Groups the game-control and status signals of the mole scheduler.
//   master : the surrounding game logic (drives tick/start/rng/hit,
//            observes mole/score/miss/game_over status)
//   slave  : mole_scheduler itself
//   Signals:
//     tick        1-cycle timebase strobe
//     start       1-cycle new-game pulse
//     rand_num    16-bit rng value, changes without a strobe
//     hit_valid   1-cycle strike pulse
//     hit_idx     hole struck, valid with hit_valid
//     mole_onehot bit i high while mole i is up
//     score       hit count, saturating at 255
//     misses      miss count
//     game_over   high while the game is over
interface mole_scheduler_if #(
   parameter int N_MOLES = 9
);
   logic               tick;
   logic               start;
   logic [15:0]        rand_num;
   logic               hit_valid;
   logic [3:0]         hit_idx;
   logic [N_MOLES-1:0] mole_onehot;
   logic [7:0]         score;
   logic [3:0]         misses;
   logic               game_over;

   modport master (
      output tick, start, rand_num, hit_valid, hit_idx,
      input  mole_onehot, score, misses, game_over
   );

   modport slave (
      input  tick, start, rand_num, hit_valid, hit_idx,
      output mole_onehot, score, misses, game_over
   );
endinterface

// File: rtl/mole_scheduler.sv
// mole_scheduler
//   Runs whack-a-mole rounds from a free-running 16-bit random stream.
//   Each fresh rng value picks the mole, its up-time and the gap before it
//   pops up. Hits on the raised mole score; letting it expire costs a miss,
//   and MAX_MISS misses end the game.
//   Ports:
//     clk    system clock
//     reset  asynchronous, active-high reset
//     bus    mole_scheduler_if.slave (tick/start/rand_num/hit in,
//            mole_onehot/score/misses/game_over out, all outputs registered)
module mole_scheduler #(
   parameter int N_MOLES  = 9,
   parameter int UP_MIN   = 8,
   parameter int GAP_MIN  = 2,
   parameter int MAX_MISS = 3
) (
   input  logic              clk,
   input  logic              reset,
   mole_scheduler_if.slave   bus
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      FETCH = 3'd1,
      GAP   = 3'd2,
      UP    = 3'd3,
      OVER  = 3'd4
   } state_t;

   typedef logic [N_MOLES-1:0] mole_t;

   state_t      state_q,     state_d;
   logic [15:0] last_num_q,  last_num_d;
   logic [3:0]  idx_q,       idx_d;
   logic [5:0]  up_len_q,    up_len_d;
   logic [5:0]  cnt_q,       cnt_d;
   mole_t       mole_q,      mole_d;
   logic [7:0]  score_q,     score_d;
   logic [3:0]  misses_q,    misses_d;
   logic        game_over_q, game_over_d;

   // Random decode of the value currently on the rng bus. Only used on the
   // cycle FETCH accepts a fresh value.
   // idx scales R[7:0] into 0..N_MOLES-1 without a divider; the product is
   // below 4096 for N_MOLES <= 16 so the result fits in 4 bits.
   logic [3:0]  idx_dec;
   logic [5:0]  up_dec;
   logic [5:0]  gap_dec;
   logic [3:0]  misses_inc;
   logic        hit_match;

   always_comb begin
      idx_dec    = 4'((16'(bus.rand_num[7:0]) * 16'(N_MOLES)) >> 8);
      up_dec     = 6'(UP_MIN)  + {2'b00, bus.rand_num[11:8]};
      gap_dec    = 6'(GAP_MIN) + {2'b00, bus.rand_num[15:12]};
      misses_inc = misses_q + 4'd1;
      hit_match  = bus.hit_valid && (bus.hit_idx == idx_q);
   end

   always_comb begin
      state_d     = state_q;
      last_num_d  = last_num_q;
      idx_d       = idx_q;
      up_len_d    = up_len_q;
      cnt_d       = cnt_q;
      mole_d      = mole_q;
      score_d     = score_q;
      misses_d    = misses_q;
      game_over_d = game_over_q;

      // start wins over everything else, in every state
      if (bus.start) begin
         score_d     = 8'd0;
         misses_d    = 4'd0;
         game_over_d = 1'b0;
         mole_d      = '0;
         state_d     = FETCH;
      end else begin
         case (state_q)
            IDLE: begin
            end

            // Wait for the rng to move on so no value is consumed twice.
            FETCH: begin
               if (bus.rand_num != last_num_q) begin
                  last_num_d = bus.rand_num;
                  idx_d      = idx_dec;
                  up_len_d   = up_dec;
                  cnt_d      = gap_dec;
                  state_d    = GAP;
               end
            end

            GAP: begin
               if (bus.tick) begin
                  if (cnt_q == 6'd1) begin
                     cnt_d   = up_len_q;
                     mole_d  = mole_t'(1) << idx_q;
                     state_d = UP;
                  end else begin
                     cnt_d = cnt_q - 6'd1;
                  end
               end
            end

            // A matching hit is checked first so a hit on the expiring tick
            // still scores.
            UP: begin
               if (hit_match) begin
                  if (score_q != 8'hFF) score_d = score_q + 8'd1;
                  mole_d  = '0;
                  state_d = FETCH;
               end else if (bus.tick) begin
                  if (cnt_q == 6'd1) begin
                     misses_d = misses_inc;
                     mole_d   = '0;
                     if (misses_inc == 4'(MAX_MISS)) begin
                        game_over_d = 1'b1;
                        state_d     = OVER;
                     end else begin
                        state_d = FETCH;
                     end
                  end else begin
                     cnt_d = cnt_q - 6'd1;
                  end
               end
            end

            OVER: begin
            end

            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         last_num_q  <= 16'd0;
         idx_q       <= 4'd0;
         up_len_q    <= 6'd0;
         cnt_q       <= 6'd0;
         mole_q      <= '0;
         score_q     <= 8'd0;
         misses_q    <= 4'd0;
         game_over_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         last_num_q  <= last_num_d;
         idx_q       <= idx_d;
         up_len_q    <= up_len_d;
         cnt_q       <= cnt_d;
         mole_q      <= mole_d;
         score_q     <= score_d;
         misses_q    <= misses_d;
         game_over_q <= game_over_d;
      end
   end

   assign bus.mole_onehot = mole_q;
   assign bus.score       = score_q;
   assign bus.misses      = misses_q;
   assign bus.game_over   = game_over_q;

endmodule

// File: tb/tb_mole_scheduler.sv
// tb_mole_scheduler
//   Directed scenarios followed by a randomized run, every cycle compared
//   against a round-level reference model of the game rules.
module tb_mole_scheduler;
   localparam int N_MOLES  = 9;
   localparam int UP_MIN   = 8;
   localparam int GAP_MIN  = 2;
   localparam int MAX_MISS = 3;

   localparam int P_IDLE  = 0;
   localparam int P_WAIT  = 1;
   localparam int P_GAP   = 2;
   localparam int P_UP    = 3;
   localparam int P_OVER  = 4;

   logic clk = 1'b0;
   logic reset;
   int   errors = 0;
   int   checks = 0;

   always #5 clk = ~clk;

   mole_scheduler_if #(.N_MOLES(N_MOLES)) bus ();

   mole_scheduler #(
      .N_MOLES (N_MOLES),
      .UP_MIN  (UP_MIN),
      .GAP_MIN (GAP_MIN),
      .MAX_MISS(MAX_MISS)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   // Reference model: phase of the current round plus plain integers.
   int m_phase, m_last, m_idx, m_up_len, m_left, m_score, m_miss, m_over;

   task automatic model_edge(input logic r, input logic t, input logic s,
                             input logic hv, input int hi, input int rn);
      if (r) begin
         m_phase = P_IDLE; m_last = 0; m_idx = 0; m_up_len = 0; m_left = 0;
         m_score = 0; m_miss = 0; m_over = 0;
      end else if (s) begin
         m_phase = P_WAIT; m_score = 0; m_miss = 0; m_over = 0;
      end else if (m_phase == P_WAIT) begin
         if (rn != m_last) begin
            m_last   = rn;
            m_idx    = ((rn % 256) * N_MOLES) / 256;
            m_up_len = UP_MIN + (rn / 256) % 16;
            m_left   = GAP_MIN + rn / 4096;
            m_phase  = P_GAP;
         end
      end else if (m_phase == P_GAP) begin
         if (t) begin
            m_left = m_left - 1;
            if (m_left == 0) begin
               m_phase = P_UP;
               m_left  = m_up_len;
            end
         end
      end else if (m_phase == P_UP) begin
         if (hv && hi == m_idx) begin
            m_score = (m_score < 255) ? m_score + 1 : 255;
            m_phase = P_WAIT;
         end else if (t) begin
            m_left = m_left - 1;
            if (m_left == 0) begin
               m_miss  = m_miss + 1;
               m_over  = (m_miss == MAX_MISS);
               m_phase = m_over ? P_OVER : P_WAIT;
            end
         end
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock: drive inputs, advance DUT and model, compare all outputs.
   task automatic step(input logic t, input logic s, input logic hv, input logic [3:0] hi);
      logic r_now;
      int   exp_mole;
      bus.tick = t; bus.start = s; bus.hit_valid = hv; bus.hit_idx = hi;
      r_now = reset;
      @(posedge clk);
      #1;
      model_edge(r_now, t, s, hv, int'(hi), int'(bus.rand_num));
      bus.tick = 1'b0; bus.start = 1'b0; bus.hit_valid = 1'b0;
      exp_mole = (m_phase == P_UP) ? (1 << m_idx) : 0;
      chk("mole_onehot", 32'(bus.mole_onehot), 32'(exp_mole));
      chk("score",       32'(bus.score),       32'(m_score));
      chk("misses",      32'(bus.misses),      32'(m_miss));
      chk("game_over",   32'(bus.game_over),   32'(m_over));
   endtask

   initial begin
      int n;
      logic [3:0] hi;
      reset = 1'b1;
      bus.tick = 1'b0; bus.start = 1'b0; bus.hit_valid = 1'b0;
      bus.hit_idx = 4'd0; bus.rand_num = 16'd0;
      model_edge(1'b1, 1'b0, 1'b0, 1'b0, 0, 0);

      // reset state
      step(0, 0, 0, 0);
      step(0, 0, 0, 0);
      chk("rst_mole", 32'(bus.mole_onehot), 32'd0);
      chk("rst_score", 32'(bus.score), 32'd0);
      reset = 1'b0;
      step(1, 0, 1, 4'd0);
      step(1, 0, 0, 0);

      // mole 4 pops after 5 ticks, wrong hole ignored, expires after 18
      bus.rand_num = 16'h3A80;
      step(0, 1, 0, 0);
      step(0, 0, 0, 0);
      repeat (4) step(1, 0, 0, 0);
      chk("s1_gap_mole", 32'(bus.mole_onehot), 32'd0);
      step(1, 0, 0, 0);
      chk("s1_up_mole", 32'(bus.mole_onehot), 32'h010);
      step(0, 0, 1, 4'd2);
      chk("s3_wrong_score", 32'(bus.score), 32'd0);
      chk("s3_wrong_mole", 32'(bus.mole_onehot), 32'h010);
      repeat (17) step(1, 0, 0, 0);
      chk("s1_still_up", 32'(bus.mole_onehot), 32'h010);
      step(1, 0, 0, 0);
      chk("s3_miss", 32'(bus.misses), 32'd1);
      chk("s3_miss_mole", 32'(bus.mole_onehot), 32'd0);

      // rng held constant: stays in FETCH
      repeat (10) step(1, 0, 0, 0);
      chk("s6_hold_mole", 32'(bus.mole_onehot), 32'd0);

      // hit on mole 4
      bus.rand_num = 16'h3A81;
      step(0, 0, 0, 0);
      repeat (5) step(1, 0, 0, 0);
      chk("s2_up_mole", 32'(bus.mole_onehot), 32'h010);
      step(0, 0, 1, 4'd4);
      chk("s2_score", 32'(bus.score), 32'd1);
      chk("s2_mole_down", 32'(bus.mole_onehot), 32'd0);
      repeat (8) step(1, 0, 0, 0);
      chk("s2_no_fresh", 32'(bus.mole_onehot), 32'd0);

      // two more expiries end the game
      bus.rand_num = 16'h1005;
      repeat (12) step(1, 0, 0, 0);
      chk("s4_miss2", 32'(bus.misses), 32'd2);
      bus.rand_num = 16'h1006;
      repeat (12) step(1, 0, 0, 0);
      chk("s4_over", 32'(bus.game_over), 32'd1);
      chk("s4_miss3", 32'(bus.misses), 32'd3);
      bus.rand_num = 16'h2222;
      repeat (6) step(1, 0, 1, 4'd0);
      chk("s4_frozen_score", 32'(bus.score), 32'd1);
      chk("s4_frozen_mole", 32'(bus.mole_onehot), 32'd0);
      step(0, 1, 0, 0);
      chk("s4_restart_over", 32'(bus.game_over), 32'd0);
      chk("s4_restart_miss", 32'(bus.misses), 32'd0);
      chk("s4_restart_score", 32'(bus.score), 32'd0);

      // matching hit on the expiring tick counts as a hit
      bus.rand_num = 16'h0120;
      step(0, 0, 0, 0);
      repeat (2) step(1, 0, 0, 0);
      n = 0;
      while (m_left > 1 && n < 64) begin step(1, 0, 0, 0); n++; end
      step(1, 0, 1, 4'd1);
      chk("s5_hit_expire_score", 32'(bus.score), 32'd1);
      chk("s5_hit_expire_miss", 32'(bus.misses), 32'd0);

      // start with hit in the same cycle restarts
      bus.rand_num = 16'h0121;
      step(0, 0, 0, 0);
      repeat (2) step(1, 0, 0, 0);
      chk("s5_up_again", 32'(bus.mole_onehot), 32'h002);
      step(0, 1, 1, 4'd1);
      chk("s5_start_hit_score", 32'(bus.score), 32'd0);
      chk("s5_start_hit_mole", 32'(bus.mole_onehot), 32'd0);

      // reset in the middle of UP
      bus.rand_num = 16'h0130;
      step(0, 0, 0, 0);
      repeat (2) step(1, 0, 0, 0);
      chk("s6_up_pre_reset", 32'(bus.mole_onehot), 32'h002);
      reset = 1'b1;
      step(1, 0, 0, 0);
      chk("s6_reset_mole", 32'(bus.mole_onehot), 32'd0);
      chk("s6_reset_over", 32'(bus.game_over), 32'd0);
      reset = 1'b0;

      // score saturation
      step(0, 1, 0, 0);
      for (int k = 0; k < 260; k++) begin
         bus.rand_num = 16'h0800 + 16'(k);
         n = 0;
         while (m_phase != P_UP && n < 50) begin step(1, 0, 0, 0); n++; end
         chk("sat_wait", 32'(n < 50), 32'd1);
         step(0, 0, 1, 4'(m_idx));
      end
      chk("sat_score", 32'(bus.score), 32'd255);

      // randomized play
      for (int c = 0; c < 3000; c++) begin
         if (c % 16 == 0) bus.rand_num = 16'($urandom);
         reset = ($urandom_range(0, 199) == 0);
         hi = ($urandom_range(0, 1) == 0) ? 4'(m_idx) : 4'($urandom_range(0, 15));
         step(1'($urandom_range(0, 1)), ($urandom_range(0, 99) == 0),
              ($urandom_range(0, 3) == 0), hi);
         if (reset) begin
            reset = 1'b0;
            step(0, 1, 0, 0);
         end
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
